// File: rtl/lattice_sched_pkg.sv
// rtl/lattice_sched_pkg.sv - shared state encoding and width helper for the lattice job scheduler
package lattice_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      FLUSH,
      REPORT
   } sched_state_e;

   // Upper nonce bits driven by the scheduler; the core INDEX fills the rest.
   function automatic int base_width(input int nonce_bits, input int log2_cores);
      return nonce_bits - log2_cores;
   endfunction

endpackage

// File: rtl/lattice_drain_counter.sv
// rtl/lattice_drain_counter.sv - loadable down-counter that times out the lattice pipeline
module lattice_drain_counter #(
   parameter  int PIPE_LATENCY = 4,
   localparam int CW           = $clog2(PIPE_LATENCY + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(PIPE_LATENCY);
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Flags the cycle whose decrement brings the count to zero, so the owner
   // can leave DRAIN/FLUSH on that same edge.
   assign zero = dec && !load && (count == CW'(1));

endmodule

// File: rtl/lattice_job_scheduler.sv
// rtl/lattice_job_scheduler.sv - issues base nonces to the hashing lattice and reports the job outcome
module lattice_job_scheduler
   import lattice_sched_pkg::*;
#(
   parameter  int LOG2_NUM_CORES = 1,
   parameter  int NONCE_BITS     = 32,
   parameter  int PIPE_LATENCY   = 4,
   localparam int BW             = base_width(NONCE_BITS, LOG2_NUM_CORES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hdr_valid,
   output logic                  hdr_ready,
   input  logic                  abort,
   output logic                  validOut,
   output logic                  newBlockOut,
   output logic [BW-1:0]         base_nonce,
   input  logic                  res_valid,
   input  logic                  res_success,
   input  logic [NONCE_BITS-1:0] res_nonce,
   output logic                  done_valid,
   output logic                  done_found,
   output logic [NONCE_BITS-1:0] done_nonce,
   input  logic                  done_ack,
   output logic                  busy
);

   sched_state_e          state, state_n;
   logic                  valid_n, newblk_n, dv_n, df_n;
   logic [BW-1:0]         base_n;
   logic [NONCE_BITS-1:0] dn_n;
   logic                  cnt_load, cnt_dec, cnt_zero;
   logic                  hit;

   assign hit     = res_valid && res_success;
   assign cnt_dec = (state == DRAIN) || (state == FLUSH);

   lattice_drain_counter #(
      .PIPE_LATENCY(PIPE_LATENCY)
   ) u_drain_counter (
      .clk (clk),
      .rst (rst),
      .load(cnt_load),
      .dec (cnt_dec),
      .zero(cnt_zero)
   );

   always_comb begin
      state_n  = state;
      valid_n  = 1'b0;
      newblk_n = 1'b0;
      base_n   = base_nonce;
      dv_n     = done_valid;
      df_n     = done_found;
      dn_n     = done_nonce;
      cnt_load = 1'b0;
      case (state)
         IDLE: begin
            if (hdr_valid && hdr_ready) begin
               state_n  = RUN;
               valid_n  = 1'b1;
               newblk_n = 1'b1;
               base_n   = '0;
               df_n     = 1'b0;
               dn_n     = '0;
            end
         end
         RUN: begin
            // Priority: abort, then hit, then end of nonce space.
            if (abort) begin
               state_n  = FLUSH;
               cnt_load = 1'b1;
            end else if (hit) begin
               state_n = REPORT;
               dv_n    = 1'b1;
               df_n    = 1'b1;
               dn_n    = res_nonce;
            end else if (&base_nonce) begin
               state_n  = DRAIN;
               cnt_load = 1'b1;
            end else begin
               valid_n = 1'b1;
               base_n  = base_nonce + 1'b1;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_n  = FLUSH;
               cnt_load = 1'b1;
            end else if (hit) begin
               state_n = REPORT;
               dv_n    = 1'b1;
               df_n    = 1'b1;
               dn_n    = res_nonce;
            end else if (cnt_zero) begin
               state_n = REPORT;
               dv_n    = 1'b1;
               df_n    = 1'b0;
               dn_n    = '0;
            end
         end
         FLUSH: begin
            if (cnt_zero) state_n = IDLE;
         end
         REPORT: begin
            if (done_ack) begin
               state_n = IDLE;
               dv_n    = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         validOut    <= 1'b0;
         newBlockOut <= 1'b0;
         base_nonce  <= '0;
         done_valid  <= 1'b0;
         done_found  <= 1'b0;
         done_nonce  <= '0;
         busy        <= 1'b0;
         hdr_ready   <= 1'b0;
      end else begin
         state       <= state_n;
         validOut    <= valid_n;
         newBlockOut <= newblk_n;
         base_nonce  <= base_n;
         done_valid  <= dv_n;
         done_found  <= df_n;
         done_nonce  <= dn_n;
         busy        <= (state_n != IDLE);
         hdr_ready   <= (state_n == IDLE);
      end
   end

endmodule
